// File: rtl/adc_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_meas_pkg
// Description : Shared types and constants for the ADC measurement capture
//               engine (FSM state encoding, accumulator and counter widths).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_meas_pkg;

    // Accumulator width: 16-bit sample plus up to 15 bits of growth.
    localparam int C_ACC_WIDTH      = 32;
    // Width of the averaging exponent k (samples per point = 2^k).
    localparam int C_LOG2_AVG_WIDTH = 4;
    // Sample counter width; must hold 2^(2^C_LOG2_AVG_WIDTH - 1) - 1.
    localparam int C_CNT_WIDTH      = 1 << C_LOG2_AVG_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage : adc_meas_pkg
`default_nettype wire

// File: rtl/adc_meas_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_meas_capture_if
// Description : Control, ADC sample and RAM write-port bundle of the capture
//               engine. "master" is the fabric/RAM side, "slave" the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_meas_capture_if
    import adc_meas_pkg::*;
#(
    parameter int G_SAMPLE_WIDTH = 16,
    parameter int G_ADDR_WIDTH   = 12
);
    logic                        start_i;
    logic                        abort_i;
    logic                        trigger_i;
    logic [C_LOG2_AVG_WIDTH-1:0] avg_log2_i;
    logic [G_ADDR_WIDTH-1:0]     npoints_i;
    logic                        adc_valid_i;
    logic [G_SAMPLE_WIDTH-1:0]   adc_data_i;
    logic [G_ADDR_WIDTH-1:0]     meas_adr_o;
    logic                        meas_we_o;
    logic [C_ACC_WIDTH-1:0]      meas_dat_o;
    logic                        busy_o;
    logic                        done_o;

    modport master (
        output start_i, abort_i, trigger_i, avg_log2_i, npoints_i,
               adc_valid_i, adc_data_i,
        input  meas_adr_o, meas_we_o, meas_dat_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, trigger_i, avg_log2_i, npoints_i,
               adc_valid_i, adc_data_i,
        output meas_adr_o, meas_we_o, meas_dat_o, busy_o, done_o
    );

endinterface : adc_meas_capture_if
`default_nettype wire

// File: rtl/adc_meas_accum.sv
`default_nettype none
// ============================================================================
// Module      : adc_meas_accum
// Description : Sums 2^k signed samples, flags the completing sample and
//               presents the arithmetically shifted average combinationally
//               in that same cycle. Self-clears on completion so a sample in
//               the following cycle starts the next point.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_meas_accum
    import adc_meas_pkg::*;
#(
    parameter int G_SAMPLE_WIDTH = 16
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        clear,
    input  wire logic                        valid,
    input  wire logic [G_SAMPLE_WIDTH-1:0]   data,
    input  wire logic [C_LOG2_AVG_WIDTH-1:0] k,
    output logic                             complete,
    output logic [C_ACC_WIDTH-1:0]           result
);

    logic signed [C_ACC_WIDTH-1:0] r_acc;
    logic        [C_CNT_WIDTH-1:0] r_cnt;
    logic signed [C_ACC_WIDTH-1:0] w_sum;
    logic        [C_CNT_WIDTH-1:0] w_last;

    // Running sum including the current sample, so the completing sample
    // needs no extra cycle before the result is available.
    assign w_sum    = r_acc + $signed({{(C_ACC_WIDTH-G_SAMPLE_WIDTH){data[G_SAMPLE_WIDTH-1]}}, data});
    // Counter value held just before the 2^k-th sample arrives.
    assign w_last   = (C_CNT_WIDTH'(1) << k) - C_CNT_WIDTH'(1);
    assign complete = valid && (r_cnt == w_last);
    // Arithmetic shift: truncation toward negative infinity.
    assign result   = w_sum >>> k;

    // Accumulate valid samples; restart from zero on clear or point completion.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (valid) begin
            if (complete) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + C_CNT_WIDTH'(1);
            end
        end
    end

endmodule : adc_meas_accum
`default_nettype wire

// File: rtl/adc_meas_capture.sv
`default_nettype none
// ============================================================================
// Module      : adc_meas_capture
// Description : Triggered ADC capture engine. Averages 2^k samples per point
//               and writes one 32-bit result per point into consecutive RAM
//               words starting at address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_meas_capture
    import adc_meas_pkg::*;
#(
    parameter int G_SAMPLE_WIDTH = 16,
    parameter int G_ADDR_WIDTH   = 12
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    adc_meas_capture_if.slave bus
);

    state_t                      r_state;
    logic [C_LOG2_AVG_WIDTH-1:0] r_k;
    logic [G_ADDR_WIDTH-1:0]     r_npoints;
    logic [G_ADDR_WIDTH-1:0]     r_idx;
    logic [G_ADDR_WIDTH-1:0]     r_adr;
    logic [C_ACC_WIDTH-1:0]      r_dat;
    logic                        r_we;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_run;
    logic                        w_complete;
    logic [C_ACC_WIDTH-1:0]      w_result;

    // Samples only count in RUN; outside RUN the accumulator is held clear so
    // a fresh capture always starts from zero.
    assign w_run = (r_state == RUN);

    adc_meas_accum #(
        .G_SAMPLE_WIDTH (G_SAMPLE_WIDTH)
    ) u_accum (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (!w_run),
        .valid    (w_run && bus.adc_valid_i),
        .data     (bus.adc_data_i),
        .k        (r_k),
        .complete (w_complete),
        .result   (w_result)
    );

    // Capture FSM with registered RAM-port and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_npoints <= '0;
            r_idx     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Start takes precedence over a simultaneous abort.
                    if (bus.start_i) begin
                        r_k       <= bus.avg_log2_i;
                        r_npoints <= bus.npoints_i;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (bus.abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (bus.trigger_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Abort suppresses a point completing in the same cycle.
                    if (bus.abort_i) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_complete) begin
                        r_we  <= 1'b1;
                        r_adr <= r_idx;
                        r_dat <= w_result;
                        r_idx <= r_idx + G_ADDR_WIDTH'(1);
                        if (r_idx == r_npoints) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.meas_adr_o = r_adr;
    assign bus.meas_we_o  = r_we;
    assign bus.meas_dat_o = r_dat;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;

endmodule : adc_meas_capture
`default_nettype wire

// File: tb/tb_adc_meas_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_meas_capture
// Description : Self-checking bench for adc_meas_capture: per-cycle vector
//               table plus hand-written reset and k = 15 sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_meas_capture;

    typedef struct {
        logic        start;
        logic        abort;
        logic        trigger;
        logic [3:0]  k;
        logic [11:0] np;
        logic        valid;
        logic [15:0] data;
        logic        we;
        logic [11:0] adr;
        logic [31:0] dat;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t vecs[$];

    adc_meas_capture_if #(.G_SAMPLE_WIDTH(16), .G_ADDR_WIDTH(12)) intf ();

    adc_meas_capture #(
        .G_SAMPLE_WIDTH (16),
        .G_ADDR_WIDTH   (12)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic ab, input logic tr,
                                input logic [3:0] k, input logic [11:0] np,
                                input logic v, input logic [15:0] d,
                                input logic we, input logic [11:0] adr,
                                input logic [31:0] dat, input logic busy,
                                input logic done);
        vec_t r;
        r.start = st; r.abort = ab; r.trigger = tr; r.k = k; r.np = np;
        r.valid = v; r.data = d; r.we = we; r.adr = adr; r.dat = dat;
        r.busy = busy; r.done = done;
        return r;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        intf.start_i     = v.start;
        intf.abort_i     = v.abort;
        intf.trigger_i   = v.trigger;
        intf.avg_log2_i  = v.k;
        intf.npoints_i   = v.np;
        intf.adc_valid_i = v.valid;
        intf.adc_data_i  = v.data;
    endtask

    task automatic check_outs(input vec_t v, input int row);
        check("we",   row, 32'(intf.meas_we_o), 32'(v.we));
        check("adr",  row, 32'(intf.meas_adr_o), 32'(v.adr));
        check("dat",  row, intf.meas_dat_o, v.dat);
        check("busy", row, 32'(intf.busy_o), 32'(v.busy));
        check("done", row, 32'(intf.done_o), 32'(v.done));
    endtask

    // Drive one row for a cycle and compare the registered outputs after the edge.
    task automatic apply(input vec_t v, input int row);
        drive(v);
        @(posedge clk);
        #1;
        check_outs(v, row);
    endtask

    initial begin
        bit early;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(mk(0,0,0,0,0,0,16'h0, 0,0,0,0,0));

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check_outs(mk(0,0,0,0,0,0,16'h0, 0,12'd0,32'h0,0,0), 900);
        rst = 1'b0;

        // ---- k=2, 2 points: 1,2,3,4 -> 2 ; -4,-4,-4,-5 -> -17>>>2 = -5 ----
        //                 st ab tr k  np v  data       we adr dat          bsy dn
        vecs.push_back(mk(1, 0, 0, 2, 1, 0, 16'h0000,  0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 16'd100,   0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd1,     0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd2,     0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd3,     0, 0, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd4,     1, 0, 32'h2,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFC,  0, 0, 32'h2,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFC,  0, 0, 32'h2,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFC,  0, 0, 32'h2,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFB,  1, 1, 32'hFFFFFFFB, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000,  0, 1, 32'hFFFFFFFB, 0, 0));
        // ---- k=0, 4 points back-to-back ----
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 16'h0000,  0, 1, 32'hFFFFFFFB, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000,  0, 1, 32'hFFFFFFFB, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h7FFF,  1, 0, 32'h00007FFF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h8000,  1, 1, 32'hFFFF8000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd5,     1, 2, 32'h00000005, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFF,  1, 3, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFF,  0, 3, 32'hFFFFFFFF, 0, 0));
        // ---- samples before and in the trigger cycle are ignored: (2+4)>>1 ----
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 16'd100,   0, 3, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd100,   0, 3, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 16'd100,   0, 3, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd2,     0, 3, 32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd4,     1, 0, 32'h00000003, 0, 1));
        // ---- abort with a completing sample, then restart from adr 0 ----
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 16'h0000,  0, 0, 32'h3,        1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000,  0, 0, 32'h3,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd6,     0, 0, 32'h3,        1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'd8,     0, 0, 32'h3,        0, 0));
        // start together with abort in IDLE: start wins
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 16'h0000,  0, 0, 32'h3,        1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000,  0, 0, 32'h3,        1, 0));
        // start while busy with k=0/np=0 must not take effect
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 16'd10,    0, 0, 32'h3,        1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'd20,    1, 0, 32'h0000000F, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 16'hFFFF,  0, 0, 32'h0000000F, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'hFFFE,  1, 1, 32'hFFFFFFFE, 0, 1));
        // ---- abort while ARMED ----
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000,  0, 1, 32'hFFFFFFFE, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'd9,     0, 1, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 16'd9,     0, 1, 32'hFFFFFFFE, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // ---- synchronous reset in the middle of RUN ----
        apply(mk(1, 0, 0, 0, 5, 0, 16'h0000,  0, 1, 32'hFFFFFFFE, 1, 0), 100);
        apply(mk(0, 0, 1, 0, 0, 0, 16'h0000,  0, 1, 32'hFFFFFFFE, 1, 0), 101);
        apply(mk(0, 0, 0, 0, 0, 1, 16'd7,     1, 0, 32'h00000007, 1, 0), 102);
        rst = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 1, 16'd9,     0, 0, 32'h0,        0, 0), 103);
        rst = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 1, 16'd9,     0, 0, 32'h0,        0, 0), 104);

        // ---- k=15: 32768 samples of 0x8000 -> 0xFFFF8000, no overflow ----
        apply(mk(1, 0, 0, 15, 0, 0, 16'h0000, 0, 0, 32'h0,        1, 0), 200);
        apply(mk(0, 0, 1, 0, 0, 0, 16'h0000,  0, 0, 32'h0,        1, 0), 201);
        early = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 1, 16'h8000,  0, 0, 32'h0,        0, 0));
        for (int n = 0; n < 32767; n++) begin
            @(posedge clk);
            #1;
            if (intf.meas_we_o !== 1'b0 || intf.busy_o !== 1'b1) early = 1'b1;
        end
        check("k15_no_early_write", 202, 32'(early), 32'd0);
        apply(mk(0, 0, 0, 0, 0, 1, 16'h8000,  1, 0, 32'hFFFF8000, 0, 1), 203);
        apply(mk(0, 0, 0, 0, 0, 0, 16'h0000,  0, 0, 32'hFFFF8000, 0, 0), 204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_adc_meas_capture
`default_nettype wire

// File: doc/adc_meas_capture.md
# adc_meas_capture

Triggered ADC capture engine feeding the `adc_meas` RAM port of the board CSR block. It averages 2^k consecutive ADC samples per point and writes one 32-bit result per point into sequential RAM words, starting at address 0. Software reads the results through the Wishbone side of the same RAM. Start, trigger and abort come from fabric control logic; `busy_o`/`done_o` report progress.

## Interface
- `G_SAMPLE_WIDTH`, 16, width of the signed ADC sample.
- `G_ADDR_WIDTH`, 12, RAM word-address width (4096 points max).
- `clk_i` in 1: system clock, same clock as the CSR block.
- `rst_i` in 1: **reset, synchronous, active-high** (one clock domain; fixed).
- `start_i` in 1: single-cycle arm request.
- `abort_i` in 1: cancel the capture in progress.
- `trigger_i` in 1: capture trigger, level-sampled while armed.
- `avg_log2_i` in 4: k, samples per point = 2^k (0..15); latched on start.
- `npoints_i` in 12: number of points minus 1; latched on start.
- `adc_valid_i` in 1: sample strobe.
- `adc_data_i` in `G_SAMPLE_WIDTH`: signed two's-complement sample.
- `meas_adr_o` out `G_ADDR_WIDTH`: RAM word address; drives `adc_meas_adr_i`.
- `meas_we_o` out 1: single-cycle write strobe; drives `adc_meas_data_we_i`.
- `meas_dat_o` out 32: averaged result; drives `adc_meas_data_dat_i`.
- `busy_o` out 1: high in ARMED and RUN.
- `done_o` out 1: single-cycle pulse when the last point is written.

## Operation
- FSM states: IDLE, ARMED, RUN.
  - IDLE: `start_i` latches `avg_log2_i` and `npoints_i`, clears the point index and accumulator, and moves to ARMED.
  - ARMED: `trigger_i` high moves to RUN. Samples in ARMED and in the trigger cycle are ignored.
  - RUN: each `adc_valid_i` adds the sign-extended sample to a 32-bit signed accumulator and increments the sample counter.
- A point completes on the sample whose count reaches 2^k. The result is (accumulator + sample) arithmetically shifted right by k: truncation toward negative infinity, sign-extended to 32 bits.
- At point completion, in the same cycle:
  - result, address and write strobe are registered;
  - the accumulator and counter are cleared;
  - the point index increments.
- No sample is lost between points. A valid sample in the write cycle counts toward the next point.
- Completion of point index `npoints_i`: pulse `done_o` with that write and return to IDLE.
- `abort_i` in ARMED or RUN: return to IDLE next cycle. No partial write, no `done_o`. `abort_i` has priority over a sample completing a point in the same cycle.
- `start_i` while busy is ignored. `start_i` together with `abort_i` in IDLE: start wins.
- Overflow cannot occur: 16 + 15 bits fit in 32 signed.
- `rst_i` mid-capture behaves like abort, and all registers take their reset values.

## Timing
- Reset values:
  - `meas_adr_o` = 0, `meas_dat_o` = 0, `meas_we_o` = 0, `done_o` = 0, `busy_o` = 0;
  - state = IDLE.
- `start_i` at cycle t: `busy_o` = 1 at t+1.
- `trigger_i` sampled in ARMED at t: the first countable sample is at t+1.
- The last sample of point p at cycle t:
  - `meas_we_o` = 1 at t+1 with `meas_adr_o` = p and `meas_dat_o` = result;
  - `meas_we_o` is low again at t+2.
- Final point: `done_o` = 1 and `busy_o` = 0 at t+1. A new `start_i` is accepted at t+1.
- k = 0: every valid sample produces a write one cycle later. Back-to-back valid samples give back-to-back writes.
- `meas_adr_o` and `meas_dat_o` hold their last value when `meas_we_o` = 0.

## Structure
- Package `adc_meas_pkg` holds:
  - the state enum (IDLE, ARMED, RUN);
  - `C_ACC_WIDTH` = 32;
  - `C_LOG2_AVG_WIDTH` = 4.
- Sub-module `adc_meas_accum` holds the accumulator, sample counter, shift and point-complete flag. Its inputs are clear, valid, data and k. The top level holds the FSM, point index and RAM-port registers.

## Test plan
- k = 2, npoints = 1 (2 points), samples 1,2,3,4,−4,−4,−4,−5 back-to-back → writes adr 0 = 0x00000002, adr 1 = 0xFFFFFFFB (−17 >>> 2); `done_o` with the second write.
- k = 0, npoints = 3, valid every cycle with 0x7FFF, 0x8000, 5, −1 → four consecutive write cycles with 0x00007FFF, 0xFFFF8000, 5, 0xFFFFFFFF at adr 0..3.
- k = 15, constant sample 0x8000, npoints = 0 → single write 0xFFFF8000 after 32768 samples; no overflow.
- Samples before trigger and in the trigger cycle: k = 1, values 100 pre-trigger, then 2, 4 → adr 0 = 3.
- `abort_i` in the same cycle as a point-completing sample → no `meas_we_o`, no `done_o`, IDLE; a subsequent start writes again from adr 0.
- `rst_i` asserted mid-RUN, and `start_i` while busy → outputs return to reset values next cycle; the start while busy is ignored and the latched k and npoints are unchanged.
